// File: rtl/bin2bcd_seq_pkg.sv
// bin2bcd_seq_pkg
//   Shared definitions for the sequential binary-to-BCD converter:
//   FSM state type, BCD digit width and the saturation digit value.
package bin2bcd_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] BCD_NINE = 4'd9;

endpackage

// File: rtl/bin2bcd_seq_if.sv
// bin2bcd_seq_if
//   Handshake/result bundle between a conversion requester and bin2bcd_seq.
//   start  : request a conversion (requester -> converter)
//   bin    : binary operand, BIN_W bits (requester -> converter)
//   busy   : conversion in flight
//   done   : one-cycle pulse when bcd/ovf/blank update
//   bcd    : packed BCD result, digit i at [4i+3:4i]
//   ovf    : result saturated to all nines
//   blank  : leading-zero blank mask, bit i blanks digit i
//   Modports: master (requester side), slave (converter side).
interface bin2bcd_seq_if
    import bin2bcd_seq_pkg::*;
#(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 5
);
    logic                        start;
    logic [BIN_W-1:0]            bin;
    logic                        busy;
    logic                        done;
    logic [DIGIT_W*DIGITS-1:0]   bcd;
    logic                        ovf;
    logic [DIGITS-1:0]           blank;

    modport master (
        output start, bin,
        input  busy, done, bcd, ovf, blank
    );

    modport slave (
        input  start, bin,
        output busy, done, bcd, ovf, blank
    );
endinterface

// File: rtl/bin2bcd_seq_add3.sv
// bcd_add3
//   Double-dabble digit correction: adds 3 to a BCD digit that is 5 or more,
//   so the following left shift carries correctly into the next digit.
//   din  : 4-bit scratch digit
//   dout : corrected digit (4-bit, no carry out)
module bcd_add3
    import bin2bcd_seq_pkg::*;
(
    input  logic [DIGIT_W-1:0] din,
    output logic [DIGIT_W-1:0] dout
);
    always_comb begin
        dout = (din >= 4'd5) ? din + 4'd3 : din;
    end
endmodule

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq
//   Sequential double-dabble converter, one shift per clock. The result
//   registers only change on the done pulse, so downstream 7-segment
//   decoders never see a partial value.
//   clk : system clock, rising edge
//   rst : asynchronous active-high reset
//   bus : bin2bcd_seq_if.slave (start/bin in; busy/done/bcd/ovf/blank out)
//   Optional feature: define BIN2BCD_LEADING_BLANK_EN to register a
//   leading-zero blank mask; otherwise blank is tied to zero.
module bin2bcd_seq
    import bin2bcd_seq_pkg::*;
#(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 5
)(
    input  logic            clk,
    input  logic            rst,
    bin2bcd_seq_if.slave    bus
);
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam int SCR_W = DIGIT_W * DIGITS;

    state_t             state;
    logic [BIN_W-1:0]   sreg;
    logic [SCR_W-1:0]   scratch;
    logic [SCR_W-1:0]   adj;
    logic [CNT_W-1:0]   cnt;
    logic               sticky;
    logic               busy_r;
    logic               done_r;
    logic [SCR_W-1:0]   bcd_r;
    logic               ovf_r;
    logic               accept;
    logic [SCR_W-1:0]   result;

    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .din  (scratch[g*DIGIT_W +: DIGIT_W]),
            .dout (adj[g*DIGIT_W +: DIGIT_W])
        );
    end

    assign accept = bus.start && (state == ST_IDLE || state == ST_DONE);
    assign result = sticky ? {DIGITS{BCD_NINE}} : scratch;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            sreg    <= '0;
            scratch <= '0;
            cnt     <= '0;
            sticky  <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            bcd_r   <= '0;
            ovf_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                ST_SHIFT: begin
                    // {scratch, sreg} <<= 1 after correction; the bit leaving
                    // the top digit means the value needs more digits
                    scratch <= {adj[SCR_W-2:0], sreg[BIN_W-1]};
                    sreg    <= sreg << 1;
                    sticky  <= sticky | adj[SCR_W-1];
                    cnt     <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state  <= ST_DONE;
                        busy_r <= 1'b0;
                    end
                end
                ST_DONE: begin
                    bcd_r  <= result;
                    ovf_r  <= sticky;
                    done_r <= 1'b1;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
            // accepting start overrides the DONE->IDLE step (back-to-back)
            if (accept) begin
                sreg    <= bus.bin;
                scratch <= '0;
                sticky  <= 1'b0;
                cnt     <= CNT_W'(BIN_W);
                busy_r  <= 1'b1;
                state   <= ST_SHIFT;
            end
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.bcd  = bcd_r;
    assign bus.ovf  = ovf_r;

`ifdef BIN2BCD_LEADING_BLANK_EN
    localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1);

    logic [DIGITS-1:0] blank_r;
    logic [DIGITS-1:0] blank_next;
    logic              all_zero;

    // digit i blanks only if it and every digit above it are zero;
    // digit 0 is never blanked so zero still shows one "0"
    always_comb begin
        blank_next = '0;
        all_zero   = 1'b1;
        for (int unsigned i = DIGITS - 1; i >= 1; i--) begin
            if (result[i*DIGIT_W +: DIGIT_W] != '0) all_zero = 1'b0;
            blank_next[i] = all_zero;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                    blank_r <= BLANK_RST;
        else if (state == ST_DONE)  blank_r <= blank_next;
    end

    assign bus.blank = blank_r;
`else
    assign bus.blank = '0;
`endif

endmodule
